// File: rtl/ram_ctrl_pkg.sv
// Shared MEM-stage op codes, op-class helpers and ram_ctrl FSM states.
// Byte-lane helpers assume a little-endian 32-bit SRAM word.
package ram_ctrl_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LBU = 4'd2,
    MEM_LH  = 4'd3,
    MEM_LHU = 4'd4,
    MEM_LW  = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } ram_state_e;

  function automatic logic is_load(mem_op_e op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic is_store(mem_op_e op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic mem_size_e op_size(mem_op_e op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return SZ_BYTE;
      MEM_LH, MEM_LHU, MEM_SH: return SZ_HALF;
      default:                 return SZ_WORD;
    endcase
  endfunction

  // Active-low lane enables; loads use the same lanes as stores.
  function automatic logic [3:0] byte_en_n(mem_op_e op, logic [1:0] off);
    case (op_size(op))
      SZ_BYTE: return ~(4'b0001 << off);
      SZ_HALF: return off[1] ? 4'b0011 : 4'b1100;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_replicate(mem_op_e op, logic [31:0] d);
    case (op_size(op))
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/ram_ctrl_load_align.sv
// Combinational load extraction: picks the addressed byte/half of a raw word
// and sign- or zero-extends it according to the load op.
module ram_ctrl_load_align
  import ram_ctrl_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  off_i,
  input  mem_op_e     op_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? raw_i[31:16] : raw_i[15:0];
    case (op_i)
      MEM_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: data_o = {24'h0, byte_sel};
      MEM_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: data_o = {16'h0, half_sel};
      MEM_LW:  data_o = raw_i;
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/ram_ctrl.sv
// Async-SRAM access controller behind MEM: IDLE -> WAIT_CYCLES x ACCESS -> DONE,
// success_o pulses in cycle WAIT_CYCLES+1; MEM stalls on the request until then.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        ramOp_i,
  input  logic [31:0]       ramAddr_i,
  input  logic [31:0]       storeData_i,
  output logic              success_o,
  output logic [31:0]       load_data_o,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [31:0]       sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam logic [3:0] CNT_LAST  = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] CNT_WE_UP = 4'(WAIT_CYCLES - 2);

  ram_state_e        state_q;
  logic [3:0]        cnt_q;
  mem_op_e           op_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic              drive_q;
  logic              success_q;
  logic [31:0]       load_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ce_n_q;
  logic              oe_n_q;
  logic              we_n_q;
  logic [3:0]        be_n_q;

  mem_op_e     op_in;
  logic        req_start;
  logic [31:0] aligned;
  logic        unused_addr_hi;

  assign op_in          = mem_op_e'(ramOp_i);
  assign req_start      = is_load(op_in) || is_store(op_in);
  assign unused_addr_hi = ^ramAddr_i[31:ADDR_W+2];

  ram_ctrl_load_align u_load_align (
    .raw_i  (sram_data),
    .off_i  (off_q),
    .op_i   (op_q),
    .data_o (aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      op_q      <= MEM_NOP;
      off_q     <= 2'd0;
      wdata_q   <= 32'h0;
      drive_q   <= 1'b0;
      success_q <= 1'b0;
      load_q    <= 32'h0;
      addr_q    <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      be_n_q    <= 4'hF;
    end else begin
      success_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_start) begin
            op_q    <= op_in;
            off_q   <= ramAddr_i[1:0];
            addr_q  <= ramAddr_i[ADDR_W+1:2];
            wdata_q <= store_replicate(op_in, storeData_i);
            cnt_q   <= 4'd0;
            ce_n_q  <= 1'b0;
            oe_n_q  <= ~is_load(op_in);
            we_n_q  <= ~is_store(op_in);
            drive_q <= is_store(op_in);
            be_n_q  <= byte_en_n(op_in, ramAddr_i[1:0]);
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // The latched op drives the whole access, so a flush on ramOp_i
          // cannot tear a store.
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            load_q    <= is_load(op_q) ? aligned : 32'h0;
            success_q <= 1'b1;
            cnt_q     <= 4'd0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            drive_q   <= 1'b0;
            be_n_q    <= 4'hF;
            state_q   <= ST_DONE;
          end else if (cnt_q == CNT_WE_UP) begin
            // we_n rises one cycle early so data and ce_n are held past it.
            we_n_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sram_data   = drive_q ? wdata_q : 32'bz;
  assign success_o   = success_q;
  assign load_data_o = load_q;
  assign sram_addr   = addr_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_be_n   = be_n_q;

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Memory-access controller sitting directly downstream of the MEM stage.
- Accepts the MEM stage's RAM request (op, byte address, store data) and runs a multi-cycle access on a 32-bit asynchronous SRAM.
- Returns a one-cycle success strobe plus aligned, sign/zero-extended load data.
- MEM holds its request stable and stalls the pipeline until it sees success.

Parameters:
- ADDR_W, 20, SRAM word-address width; byte address bits [ADDR_W+1:2] select the word.
- WAIT_CYCLES, 2, number of ACCESS-state cycles per transaction; legal range 2..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ramOp_i  in  4  MEM_* op code: NOP, LB, LBU, LH, LHU, LW, SB, SH, SW
- ramAddr_i  in  32  byte address; alignment already guaranteed upstream
- storeData_i  in  32  store data, right-justified
- success_o  out  1  one-cycle pulse: access complete
- load_data_o  out  32  extended load result, valid while success_o=1
- sram_addr  out  ADDR_W  SRAM word address
- sram_data  inout  32  SRAM data bus
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_be_n  out  4  byte enables, active low; bit i = byte lane i (little-endian)

Behaviour:
- Reset (rst=1 at a clk edge), all outputs registered:
  - state=IDLE, counter=0, success_o=0, load_data_o=0
  - sram_addr=0, ce_n/oe_n/we_n=1, be_n=4'hF, sram_data released (Z)
- Reset mid-access aborts immediately; no success pulse is issued.
- IDLE:
  - If ramOp_i!=NOP, latch op, byte offset addr[1:0], word address and lane-replicated store data; go to ACCESS with counter=0.
  - Drive ce_n=0 and be_n from the table below.
  - Reads: oe_n=0. Writes: oe_n=1 and drive sram_data.
- Byte enables (be_n):
  - Word ops: 0000.
  - Half ops: 1100 if addr[1]=0, 0011 if addr[1]=1.
  - Byte ops: all ones except bit addr[1:0].
  - Reads use the same enables as writes.
- Store replication:
  - SB: {4{b}}.
  - SH: {2{h}}.
  - SW: data unchanged.
- ACCESS:
  - Lasts exactly WAIT_CYCLES cycles; counter increments each cycle.
  - Writes: we_n=0 on every ACCESS cycle except the last. we_n rises one cycle before ce_n and the data drive are released, giving hold time.
  - Reads: on the last ACCESS edge, capture sram_data, then shift/extend it into load_data_o:
    - LB: sign-extended byte[addr[1:0]]
    - LBU: zero-extended byte[addr[1:0]]
    - LH: sign-extended half[addr[1]]
    - LHU: zero-extended half[addr[1]]
    - LW: full word
  - Writes set load_data_o=0.
  - Then go to DONE and deassert ce_n/oe_n/we_n, be_n=F, bus Z.
- DONE:
  - success_o=1 for exactly this cycle; always return to IDLE next edge.
  - A new request is sampled only in IDLE, so consecutive accesses have one idle gap.
- Latency: request first visible in IDLE at cycle 0 → success_o high in cycle WAIT_CYCLES+1.
- ramOp_i changing or dropping to NOP during ACCESS (exception flush) is ignored; the access completes.
  - Stores must never be torn.
  - MEM discards the stale success.
- sram_data is driven only in write ACCESS cycles; it is never driven in IDLE or DONE.

Decomposition:
- The MEM_* op codes and the op-class helpers (is_load, is_store, size) go in the shared defines file used by the MEM stage.
- One natural sub-module: load_align, combinational extraction and sign/zero extension from {raw word, offset, op}. Reused by any future cache path.

Test Plan:
- Reset: assert rst 3 cycles mid-write → all control outputs 1, be_n=F, bus Z, success_o=0; no further pulse.
- LW at 0x0000_0010, SRAM word[4]=0xDEADBEEF, WAIT=2:
  - sram_addr=4, oe_n=0, be_n=0000.
  - success_o in cycle 3 with load_data_o=0xDEADBEEF.
- SB at 0x0000_0003, data 0x000000A5:
  - be_n=0111, sram_data=0xA5A5A5A5.
  - we_n low exactly 1 cycle.
  - Readback LW shows only byte 3 changed.
- LB at offset 2 with word 0x0080_0000 → 0xFFFFFF80; LBU → 0x00000080; LH at offset 2 with word 0x8001_0000 → 0xFFFF8001; LHU → 0x00008001.
- Back-to-back SW then LW held by a model MEM stage:
  - Each gets exactly one success pulse, separated by one IDLE cycle.
  - LW returns the stored value.
- Flush during SW ACCESS (ramOp_i→NOP) → write completes with the full we_n pulse, success_o pulses once, then idle.
